router_iact_nport: RTL and testbench

Parametrised input-activation router for the PE-cluster mesh. It accepts iact words from NUM_PORTS neighbour ports under a valid/ready handshake and arbitrates one word per cycle into a small FIFO. Each FIFO head is broadcast to a configurable subset of output ports, with per-output backpressure. During a load window it also writes the words into the local PE scratchpad at auto-incrementing addresses, replacing the edge-pulse loader scheme.

---
 rtl/router_iact_nport_pkg.sv | 20 ++
 rtl/router_iact_nport_fifo.sv | 53 +++++
 rtl/router_iact_nport.sv | 180 ++++++++++++++++++
 tb/tb_router_iact_nport.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_iact_nport_pkg.sv
// Shared definitions for the iact router: neighbour port indices and load FSM encoding.
package router_pkg;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_W = 2;
  localparam int PORT_E = 3;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } load_state_e;

  // Next index in a ring of n entries, used by the round-robin pointer.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/router_iact_nport_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty; head is the oldest entry.
// Latency: a pushed word is visible on head_o the next cycle; a push while full is ignored.
module iact_fifo #(
  parameter int DATA_BITWIDTH = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DATA_BITWIDTH-1:0] push_dat_i,
  input  logic                     pop_i,
  output logic [DATA_BITWIDTH-1:0] head_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]              wr_ptr_q, wr_ptr_d;
  logic [AW:0]              rd_ptr_q, rd_ptr_d;
  logic                     do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset: contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/router_iact_nport.sv
// iact router: one word/cycle from NUM_PORTS inputs into a FIFO, head broadcast to masked outputs, optional spad load window.
// Push-to-output 1 cycle; in_ready from registered FIFO state only. ROUTER_IACT_RR_EN selects round-robin, else fixed priority.
module router_iact_nport
  import router_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int NUM_PORTS         = 4,
  parameter int FIFO_DEPTH        = 4,
  parameter int ADDR_BITWIDTH_SPAD = 9
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               in_valid_i,
  input  logic [NUM_PORTS*DATA_BITWIDTH-1:0] in_data_i,
  output logic [NUM_PORTS-1:0]               in_ready_o,
  output logic [NUM_PORTS-1:0]               out_valid_o,
  output logic [NUM_PORTS*DATA_BITWIDTH-1:0] out_data_o,
  input  logic [NUM_PORTS-1:0]               out_ready_i,
  input  logic                               cfg_we_i,
  input  logic [NUM_PORTS-1:0]               cfg_mask_i,
  output logic                               cfg_err_o,
  input  logic                               load_start_i,
  input  logic [ADDR_BITWIDTH_SPAD-1:0]      load_base_i,
  input  logic [ADDR_BITWIDTH_SPAD:0]        load_len_i,
  output logic                               spad_we_o,
  output logic [ADDR_BITWIDTH_SPAD-1:0]      spad_addr_o,
  output logic [DATA_BITWIDTH-1:0]           spad_wdata_o,
  output logic                               load_busy_o,
  output logic                               load_done_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [ADDR_BITWIDTH_SPAD:0] IDX_ONE = 1;

  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  logic [DATA_BITWIDTH-1:0] head, head_vis, push_dat;
  logic [NUM_PORTS-1:0]     grant, hs;
  logic [PW-1:0]            gnt_idx, cand;
  logic                     found;
  logic [DATA_BITWIDTH-1:0] in_word [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign in_word[i] = in_data_i[i*DATA_BITWIDTH +: DATA_BITWIDTH];
  end

  // ---------------- arbitration ----------------
`ifdef ROUTER_IACT_RR_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr_d = push ? PW'(ring_next(int'(gnt_idx), NUM_PORTS)) : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Gated by the registered full flag so out_ready never reaches in_ready.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef ROUTER_IACT_RR_EN
      cand = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
`else
      cand = PW'(PORT_N + k);
`endif
      if (!fifo_full && !found && in_valid_i[cand]) begin
        found         = 1'b1;
        grant[cand]   = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

  assign in_ready_o = grant;
  assign push       = found;
  assign push_dat   = in_word[gnt_idx];

  iact_fifo #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .push_dat_i(push_dat),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // ---------------- broadcast tracker ----------------
  logic [NUM_PORTS-1:0] mask_q, mask_d;
  logic [NUM_PORTS-1:0] sent_q, sent_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 cfg_ok;

  assign head_vis    = fifo_empty ? '0 : head;
  assign out_valid_o = fifo_empty ? '0 : (mask_q & ~sent_q);
  assign out_data_o  = {NUM_PORTS{head_vis}};
  assign hs          = out_valid_o & out_ready_i;
  // An empty mask pops immediately, which drops the word.
  assign pop         = !fifo_empty && (((sent_q | hs) & mask_q) == mask_q);

  // Mask may only change between words so a broadcast never sees two masks.
  assign cfg_ok = fifo_empty && (sent_q == '0);

  always_comb begin
    sent_d    = pop ? '0 : (sent_q | hs);
    mask_d    = (cfg_we_i && cfg_ok) ? cfg_mask_i : mask_q;
    cfg_err_d = cfg_we_i && !cfg_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      sent_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      sent_q    <= sent_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err_o = cfg_err_q;

  // ---------------- scratchpad load FSM ----------------
  load_state_e                 state_q;
  logic [ADDR_BITWIDTH_SPAD-1:0] base_q;
  logic [ADDR_BITWIDTH_SPAD:0]   len_q, idx_q;
  logic                          spad_we;

  assign spad_we = (state_q == LD_LOAD) && pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (load_start_i) begin
            if (load_len_i != '0) begin
              state_q <= LD_LOAD;
              base_q  <= load_base_i;
              len_q   <= load_len_i;
              idx_q   <= '0;
            end else begin
              state_q <= LD_DONE;
            end
          end
        end
        LD_LOAD: begin
          if (pop) begin
            idx_q <= idx_q + IDX_ONE;
            if (idx_q + IDX_ONE == len_q) state_q <= LD_DONE;
          end
        end
        LD_DONE: state_q <= LD_IDLE;
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  // Address wraps naturally at the spad width.
  assign spad_we_o    = spad_we;
  assign spad_addr_o  = spad_we ? (base_q + idx_q[ADDR_BITWIDTH_SPAD-1:0]) : '0;
  assign spad_wdata_o = spad_we ? head : '0;
  assign load_busy_o  = (state_q == LD_LOAD);
  assign load_done_o  = (state_q == LD_DONE);

endmodule

// File: tb/tb_router_iact_nport.sv
// Bench for router_iact_nport: queue-based reference model checked every cycle, plus directed literal checks.
module tb_router_iact_nport;
  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 4;
  localparam int A = 9;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid_i, in_ready_o, out_valid_o, out_ready_i, cfg_mask_i;
  logic [N*W-1:0] in_data_i, out_data_o;
  logic           cfg_we_i, cfg_err_o, load_start_i, spad_we_o, load_busy_o, load_done_o;
  logic [A-1:0]   load_base_i, spad_addr_o;
  logic [A:0]     load_len_i;
  logic [W-1:0]   spad_wdata_o;

  always #5 clk = ~clk;

  router_iact_nport #(
    .DATA_BITWIDTH(W), .NUM_PORTS(N), .FIFO_DEPTH(D), .ADDR_BITWIDTH_SPAD(A)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .cfg_we_i(cfg_we_i), .cfg_mask_i(cfg_mask_i), .cfg_err_o(cfg_err_o),
    .load_start_i(load_start_i), .load_base_i(load_base_i), .load_len_i(load_len_i),
    .spad_we_o(spad_we_o), .spad_addr_o(spad_addr_o), .spad_wdata_o(spad_wdata_o),
    .load_busy_o(load_busy_o), .load_done_o(load_done_o)
  );

  // Reference model state
  logic [W-1:0] fq[$];
  logic [N-1:0] m_mask, m_sent;
  int           m_rr, m_rem;
  bit           m_act, m_done, m_err, mvalid;
  logic [A-1:0] m_addr;

  int total = 0, bad = 0, cyc = 0;

  // Samples of the DUT outputs from the most recent cycle
  logic [N-1:0]   s_ir, s_ov;
  logic [N*W-1:0] s_od;
  logic           s_we, s_busy, s_done, s_err;
  logic [A-1:0]   s_addr;
  logic [W-1:0]   s_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [N-1:0]   e_ir, e_ov, hs;
    logic [N*W-1:0] e_od;
    bit             full, pop, e_we, nd, ok;
    int             g, p;
    #4;
    s_ir = in_ready_o; s_ov = out_valid_o; s_od = out_data_o;
    s_we = spad_we_o; s_addr = spad_addr_o; s_wd = spad_wdata_o;
    s_busy = load_busy_o; s_done = load_done_o; s_err = cfg_err_o;

    full = (fq.size() == D);
    g = -1;
    if (!full) begin
      for (int k = 0; k < N; k++) begin
`ifdef ROUTER_IACT_RR_EN
        p = (m_rr + k) % N;
`else
        p = k;
`endif
        if (g < 0 && in_valid_i[p]) g = p;
      end
    end
    e_ir = '0;
    if (g >= 0) e_ir[g] = 1'b1;
    e_ov = (fq.size() != 0) ? (m_mask & ~m_sent) : '0;
    e_od = (fq.size() != 0) ? {N{fq[0]}} : '0;
    hs   = e_ov & out_ready_i;
    pop  = (fq.size() != 0) && (((m_sent | hs) & m_mask) == m_mask);
    e_we = m_act && pop;

    if (mvalid) begin
      chk("in_ready", s_ir, e_ir);
      chk("out_valid", s_ov, e_ov);
      chk("out_data", s_od, e_od);
      chk("spad_we", s_we, e_we);
      chk("spad_addr", s_addr, e_we ? m_addr : '0);
      chk("spad_wdata", s_wd, e_we ? fq[0] : '0);
      chk("load_busy", s_busy, m_act);
      chk("load_done", s_done, m_done);
      chk("cfg_err", s_err, m_err);
    end

    if (reset) begin
      fq.delete(); m_mask = '0; m_sent = '0; m_rr = 0; m_rem = 0;
      m_act = 0; m_done = 0; m_err = 0; m_addr = '0; mvalid = 1;
    end else if (mvalid) begin
      ok    = (fq.size() == 0) && (m_sent == '0);
      m_err = cfg_we_i && !ok;
      if (cfg_we_i && ok) m_mask = cfg_mask_i;
      nd = 0;
      if (m_act) begin
        if (pop) begin
          m_addr = m_addr + 1'b1;
          m_rem--;
          if (m_rem == 0) begin m_act = 0; nd = 1; end
        end
      end else if (!m_done && load_start_i) begin
        if (load_len_i != 0) begin m_act = 1; m_addr = load_base_i; m_rem = int'(load_len_i); end
        else nd = 1;
      end
      m_done = nd;
      if (pop) begin void'(fq.pop_front()); m_sent = '0; end
      else m_sent = m_sent | hs;
      if (g >= 0) begin fq.push_back(in_data_i[g*W +: W]); m_rr = (g + 1) % N; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid_i = '0; cfg_we_i = 1'b0; load_start_i = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [N-1:0] m);
    cfg_we_i = 1'b1; cfg_mask_i = m;
    tick();
    cfg_we_i = 1'b0;
  endtask

  logic [3:0]   exp_g;
  logic [W-1:0] wd [4];
  logic         we_r [6];
  logic [A-1:0] ad_r [6];
  logic [W-1:0] wv_r [6];
  logic         dn_r [6];
  int           cnt;

  initial begin
    reset = 1'b1; in_valid_i = '0; in_data_i = '0; out_ready_i = '0;
    cfg_we_i = 1'b0; cfg_mask_i = '0; load_start_i = 1'b0; load_base_i = '0; load_len_i = '0;
    mvalid = 0; m_rr = 0;
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ov", s_ov, 0); chk("rst_od", s_od, 0); chk("rst_we", s_we, 0);
    chk("rst_busy", s_busy, 0); chk("rst_done", s_done, 0); chk("rst_err", s_err, 0);

    // Single word broadcast
    do_reset(); cfg(4'b1010);
    in_valid_i = 4'b0100; in_data_i = '0; in_data_i[2*W +: W] = 16'h1234; out_ready_i = '0;
    tick(); chk("s1_ready", s_ir, 4'b0100);
    in_valid_i = '0; out_ready_i = 4'hF;
    tick(); chk("s1_ov", s_ov, 4'b1010); chk("s1_od", s_od, {4{16'h1234}});
    tick(); chk("s1_ov_after", s_ov, 0);

    // Staggered backpressure
    do_reset(); cfg(4'b0011);
    in_valid_i = 4'b0001; in_data_i[W-1:0] = 16'hBEEF; out_ready_i = '0;
    tick();
    in_valid_i = '0; out_ready_i = 4'b0001; cnt = 0;
    tick(); cnt += int'(s_ov[0]); chk("s2_ov1", s_ov, 4'b0011);
    tick(); cnt += int'(s_ov[0]); chk("s2_ov2", s_ov, 4'b0010);
    out_ready_i = 4'b0011;
    tick(); cnt += int'(s_ov[0]); chk("s2_ov3", s_ov, 4'b0010);
    out_ready_i = '0;
    tick(); chk("s2_ov4", s_ov, 0); chk("s2_hs0", cnt, 1);

    // Contention
    do_reset(); cfg(4'hF);
    out_ready_i = 4'hF; in_valid_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      in_data_i = {$urandom, $urandom};
`ifdef ROUTER_IACT_RR_EN
      exp_g = 4'b0001 << (i % 4);
`else
      exp_g = 4'b0001;
`endif
      tick(); chk("s3_grant", s_ir, exp_g);
    end

    // Full FIFO and rejected cfg
    do_reset(); cfg(4'hF);
    out_ready_i = '0; in_valid_i = 4'hF; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      in_data_i = {$urandom, $urandom};
      tick();
      if (s_ir != '0) cnt++;
    end
    chk("s4_pushes", cnt, 4); chk("s4_ready0", s_ir, 0);
    in_valid_i = '0; cfg_we_i = 1'b1; cfg_mask_i = 4'b0001;
    tick(); cfg_we_i = 1'b0;
    tick(); chk("s4_err", s_err, 1); chk("s4_mask", s_ov, 4'hF);
    out_ready_i = 4'hF;
    repeat (5) tick();

    // Load with address wrap
    do_reset(); cfg(4'b0001); out_ready_i = 4'hF;
    load_start_i = 1'b1; load_base_i = 9'h1FE; load_len_i = 10'd3;
    tick(); load_start_i = 1'b0;
    wd[0] = 16'hA0A0; wd[1] = 16'hB1B1; wd[2] = 16'hC2C2; wd[3] = 16'hD3D3;
    for (int i = 0; i < 6; i++) begin
      in_valid_i = (i < 4) ? 4'b0001 : 4'b0000;
      in_data_i[W-1:0] = wd[i % 4];
      tick();
      we_r[i] = s_we; ad_r[i] = s_addr; wv_r[i] = s_wd; dn_r[i] = s_done;
      if (i == 0) chk("s5_busy", s_busy, 1);
    end
    chk("s5_w0", {31'd0, we_r[0]}, 0);
    chk("s5_w1", {we_r[1], ad_r[1], wv_r[1]}, {1'b1, 9'h1FE, 16'hA0A0});
    chk("s5_w2", {we_r[2], ad_r[2], wv_r[2]}, {1'b1, 9'h1FF, 16'hB1B1});
    chk("s5_w3", {we_r[3], ad_r[3], wv_r[3]}, {1'b1, 9'h000, 16'hC2C2});
    chk("s5_done3", dn_r[3], 0); chk("s5_done4", dn_r[4], 1);
    chk("s5_we4", we_r[4], 0); chk("s5_done5", dn_r[5], 0);

    // Reset mid-load, then zero-length load
    do_reset(); cfg(4'b0001); out_ready_i = 4'hF;
    load_start_i = 1'b1; load_base_i = 9'h010; load_len_i = 10'd5;
    tick(); load_start_i = 1'b0;
    in_valid_i = 4'b0001; in_data_i[W-1:0] = 16'h5A5A;
    tick(); in_valid_i = '0;
    tick(); chk("s6_we", s_we, 1); chk("s6_addr", s_addr, 9'h010);
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    chk("s6_busy", s_busy, 0); chk("s6_done", s_done, 0); chk("s6_ov", s_ov, 0);
    chk("s6_spad", {s_we, s_addr, s_wd}, 0);
    tick(); chk("s6_done_late", s_done, 0);
    load_len_i = '0; load_start_i = 1'b1;
    tick(); load_start_i = 1'b0; chk("s6_z0", s_done, 0);
    tick(); chk("s6_z1", s_done, 1);
    tick(); chk("s6_z2", s_done, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid_i   = N'($urandom_range(0, 15));
      in_data_i    = {$urandom, $urandom};
      out_ready_i  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : 4'hF;
      cfg_we_i     = ($urandom_range(0, 19) == 0);
      cfg_mask_i   = N'($urandom_range(0, 15));
      load_start_i = ($urandom_range(0, 29) == 0);
      load_base_i  = A'($urandom_range(0, 511));
      load_len_i   = (A+1)'($urandom_range(0, 8));
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; in_valid_i = '0; cfg_we_i = 1'b0; load_start_i = 1'b0; out_ready_i = 4'hF;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
